// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC point units: FSM state encoding and timing constants.
package ecc_pkg;

    localparam int DEFAULT_LEN = 256;
    localparam int MUL_CYCLES  = DEFAULT_LEN + 2;
    localparam int LATENCY     = (2 * DEFAULT_LEN + 4) * MUL_CYCLES + 3;

    typedef enum logic [3:0] {
        IDLE,
        MUL_XX,
        MUL_CUBE,
        MUL_AX,
        ADD1,
        ADD2,
        EXP_SQ,
        EXP_MUL,
        CHECK,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved modular multiplier: r = a*b mod p, LEN steps after the launch cycle.
module mod_mul_serial #(
    parameter int LEN = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [LEN-1:0] a,
    input  logic [LEN-1:0] b,
    input  logic [LEN-1:0] p,
    output logic           busy,
    output logic           done,
    output logic [LEN-1:0] r
);
    localparam int CW = $clog2(LEN + 1);

    logic [LEN-1:0] a_r, b_sh, p_r, acc;
    logic [CW-1:0]  cnt;
    logic [LEN+1:0] pw, t0, t1, t2;

    // acc < p and A < p keep 2*acc + A below 3p, so two conditional subtractions suffice
    always_comb begin
        pw = {2'b00, p_r};
        t0 = {1'b0, acc, 1'b0} + (b_sh[LEN-1] ? {2'b00, a_r} : '0);
        t1 = (t0 >= pw) ? t0 - pw : t0;
        t2 = (t1 >= pw) ? t1 - pw : t1;
    end

    assign r = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r  <= '0;
            b_sh <= '0;
            p_r  <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_r  <= a;
                b_sh <= b;
                p_r  <= p;
                acc  <= '0;
                cnt  <= CW'(LEN);
                busy <= 1'b1;
            end else if (busy) begin
                acc  <= LEN'(t2);
                b_sh <= b_sh << 1;
                cnt  <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ecc_point_decompress.sv
// Recovers affine y from (x, parity) as sqrt(x^3 + a*x + b) mod p with constant-time sequencing.
module ecc_point_decompress #(
    parameter int LEN = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [LEN-1:0] a,
    input  logic [LEN-1:0] b,
    input  logic [LEN-1:0] p,
    input  logic [LEN-1:0] x,
    input  logic           y_parity,
    output logic           busy,
    output logic           done,
    output logic           valid,
    output logic [LEN-1:0] y
);
    import ecc_pkg::*;

    localparam int IW = $clog2(LEN);

    state_t         st;
    logic [LEN-1:0] a_r, b_r, p_r, x_r, e_r, t_r, u_r, rhs_r, r_r, c_r;
    logic           par_r, bad_r, launched;
    logic [IW-1:0]  idx;

    logic           is_mul, mul_start, mul_busy, mul_done;
    logic [LEN-1:0] mul_a, mul_b, mul_r, add_x, add_y, add_res;
    logic [LEN:0]   sum;

    assign is_mul    = st inside {MUL_XX, MUL_CUBE, MUL_AX, EXP_SQ, EXP_MUL, CHECK};
    assign mul_start = is_mul && !launched && !mul_busy;

    always_comb begin
        mul_a = r_r;
        mul_b = r_r;
        case (st)
            MUL_XX:   begin mul_a = x_r; mul_b = x_r;   end
            MUL_CUBE: begin mul_a = t_r; mul_b = x_r;   end
            MUL_AX:   begin mul_a = a_r; mul_b = x_r;   end
            EXP_MUL:  begin mul_a = r_r; mul_b = rhs_r; end
            default:  begin mul_a = r_r; mul_b = r_r;   end
        endcase
    end

    // ADD1 forms t+u into rhs_r, ADD2 adds b on top of it
    always_comb begin
        add_x   = (st == ADD1) ? t_r : rhs_r;
        add_y   = (st == ADD1) ? u_r : b_r;
        sum     = {1'b0, add_x} + {1'b0, add_y};
        add_res = (sum >= {1'b0, p_r}) ? LEN'(sum - {1'b0, p_r}) : sum[LEN-1:0];
    end

    mod_mul_serial #(.LEN(LEN)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .p     (p_r),
        .busy  (mul_busy),
        .done  (mul_done),
        .r     (mul_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
            y        <= '0;
            a_r      <= '0;
            b_r      <= '0;
            p_r      <= '0;
            x_r      <= '0;
            e_r      <= '0;
            t_r      <= '0;
            u_r      <= '0;
            rhs_r    <= '0;
            r_r      <= '0;
            c_r      <= '0;
            par_r    <= 1'b0;
            bad_r    <= 1'b0;
            launched <= 1'b0;
            idx      <= '0;
        end else begin
            done <= 1'b0;
            if (mul_start)
                launched <= 1'b1;
            else if (mul_done)
                launched <= 1'b0;

            case (st)
                IDLE: if (start) begin
                    a_r   <= a;
                    b_r   <= b;
                    p_r   <= p;
                    par_r <= y_parity;
                    // out-of-range x is replaced by 0 so the multiplier operands stay below p
                    bad_r <= (x >= p);
                    x_r   <= (x >= p) ? '0 : x;
                    e_r   <= (p >> 2) + LEN'(1);
                    r_r   <= LEN'(1);
                    busy  <= 1'b1;
                    valid <= 1'b0;
                    y     <= '0;
                    st    <= MUL_XX;
                end
                MUL_XX:   if (mul_done) begin t_r <= mul_r; st <= MUL_CUBE; end
                MUL_CUBE: if (mul_done) begin t_r <= mul_r; st <= MUL_AX;   end
                MUL_AX:   if (mul_done) begin u_r <= mul_r; st <= ADD1;     end
                ADD1: begin
                    rhs_r <= add_res;
                    st    <= ADD2;
                end
                ADD2: begin
                    rhs_r <= add_res;
                    idx   <= IW'(LEN - 1);
                    st    <= EXP_SQ;
                end
                EXP_SQ: if (mul_done) begin r_r <= mul_r; st <= EXP_MUL; end
                EXP_MUL: if (mul_done) begin
                    if (e_r[idx])
                        r_r <= mul_r;
                    if (idx == '0)
                        st <= CHECK;
                    else begin
                        idx <= idx - IW'(1);
                        st  <= EXP_SQ;
                    end
                end
                CHECK: if (mul_done) begin c_r <= mul_r; st <= FIX; end
                FIX: begin
                    if (bad_r || c_r != rhs_r) begin
                        valid <= 1'b0;
                        y     <= '0;
                    end else if (r_r[0] != par_r) begin
                        valid <= (r_r != '0);
                        y     <= (r_r != '0) ? p_r - r_r : '0;
                    end else begin
                        valid <= 1'b1;
                        y     <= r_r;
                    end
                    busy <= 1'b0;
                    done <= 1'b1;
                    st   <= DONE;
                end
                DONE:    st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_point_decompress.sv
// Scoreboard bench for ecc_point_decompress on a toy curve (LEN=8, p=251, a=2, b=3).
module tb_ecc_point_decompress;
    localparam int LEN = 8;
    localparam int LAT = 203;

    logic           clk = 1'b0;
    logic           rst, start, y_parity;
    logic [LEN-1:0] a, b, p, x;
    logic           busy, done, valid;
    logic [LEN-1:0] y;

    typedef struct {
        logic           v;
        logic [LEN-1:0] y;
        int             sc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    ecc_point_decompress #(.LEN(LEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .p        (p),
        .x        (x),
        .y_parity (y_parity),
        .busy     (busy),
        .done     (done),
        .valid    (valid),
        .y        (y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // monitor: every done pulse is matched against the oldest expected result
    always @(posedge clk) begin
        #1;
        if (!rst && done) begin
            if (q.size() == 0)
                chk("spurious_done", done, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("valid", valid, e.v);
                chk("y", y, e.y);
                chk("latency", cyc - e.sc, LAT);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    task automatic issue(input logic [LEN-1:0] xi, input logic par,
                         input logic ev, input logic [LEN-1:0] ey, input bit push);
        @(negedge clk);
        x        = xi;
        y_parity = par;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) q.push_back('{ev, ey, cyc});
        chk("busy_after_accept", busy, 1);
        // captured operands must not track later input changes
        x        = ~xi;
        y_parity = ~par;
    endtask

    task automatic wait_done();
        for (int i = 0; i < LAT + 50 && q.size() != 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            chk("timeout_pending", q.size(), 0);
            q.delete();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        a = 8'd2; b = 8'd3; p = 8'd251; x = '0; y_parity = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", valid, 0);
        chk("rst_y", y, 0);
        @(negedge clk) rst = 1'b0;

        issue(8'd0,   1'b1, 1'b1, 8'd175, 1'b1); wait_done();
        issue(8'd0,   1'b0, 1'b1, 8'd76,  1'b1); wait_done();
        issue(8'd1,   1'b1, 1'b0, 8'd0,   1'b1); wait_done();
        issue(8'd250, 1'b0, 1'b1, 8'd0,   1'b1); wait_done();
        issue(8'd250, 1'b1, 1'b0, 8'd0,   1'b1); wait_done();
        issue(8'd251, 1'b0, 1'b0, 8'd0,   1'b1); wait_done();

        // a second start while busy must be ignored
        issue(8'd0, 1'b1, 1'b1, 8'd175, 1'b1);
        repeat (48) @(posedge clk);
        @(negedge clk);
        x = 8'd1; y_parity = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignore_start", busy, 1);
        wait_done();
        repeat (5) @(posedge clk);
        #1;
        chk("hold_valid", valid, 1);
        chk("hold_y", y, 175);

        // synchronous reset mid-operation
        issue(8'd0, 1'b1, 1'b1, 8'd175, 1'b0);
        repeat (99) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_y", y, 0);
        chk("midrst_valid", valid, 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_idle", busy, 0);

        issue(8'd0, 1'b1, 1'b1, 8'd175, 1'b1); wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
